msg_router: RTL and testbench

- Upstream neighbour of the single-word message assemblers.
- Consumes the received byte stream from the Arduino serial link, one byte per strobe.
- Locates the message header and validates it, then steers the payload bytes to one of NumDest destination modules.
- Drives each destination with one-hot ClearAddr/WriteByte strobes and a shared DataByte bus, and flags completion and framing errors.

---
 rtl/msg_defs.sv | 26 ++
 rtl/msg_timeout.sv | 35 +++
 rtl/msg_router.sv | 165 ++++++++++++++++
 tb/tb_msg_router.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msg_defs.sv
// Shared constants and state encoding for the serial message router.
// Frame layout on the link: SYNC1, SYNC2, count, id, then `count` payload bytes.
package msg_defs;

  localparam logic [7:0] SYNC_BYTE1     = 8'h12;
  localparam logic [7:0] SYNC_BYTE2     = 8'h34;
  localparam logic [7:0] FIRST_MSG_ID   = 8'h10;

  localparam logic [7:0] MSG_ID_DEST0   = FIRST_MSG_ID;
  localparam logic [7:0] MSG_ID_DEST1   = FIRST_MSG_ID + 8'd1;
  localparam logic [7:0] MSG_ID_DEST2   = FIRST_MSG_ID + 8'd2;
  localparam logic [7:0] MSG_ID_DEST3   = FIRST_MSG_ID + 8'd3;

  localparam int unsigned MAX_PAYLOAD    = 32;
  localparam int unsigned TIMEOUT_CYCLES = 50000;

  typedef enum logic [2:0] {
    HUNT1     = 3'd0,
    HUNT2     = 3'd1,
    GET_COUNT = 3'd2,
    GET_ID    = 3'd3,
    PAYLOAD   = 3'd4,
    DISCARD   = 3'd5
  } state_e;

endpackage

// File: rtl/msg_timeout.sv
// Idle counter: counts enabled cycles since the last clear and flags when the
// loaded limit is reached. The count saturates at the limit until cleared.
module msg_timeout #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [Width-1:0] limit_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != limit_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == limit_i);

endmodule

// File: rtl/msg_router.sv
// Hunts for the two-byte sync header, validates count and ID, then steers the
// payload to one destination with one-hot ClearAddr/WriteByte strobes.
module msg_router
  import msg_defs::*;
#(
  parameter int unsigned NumDest       = 4,
  parameter logic [7:0]  FirstMsgID    = MSG_ID_DEST0,
  parameter logic [7:0]  SyncByte1     = SYNC_BYTE1,
  parameter logic [7:0]  SyncByte2     = SYNC_BYTE2,
  parameter int unsigned MaxPayload    = MAX_PAYLOAD,
  parameter int unsigned TimeoutCycles = TIMEOUT_CYCLES
) (
  input  logic               Clock,
  input  logic               Clear_n,
  input  logic [7:0]         InByte,
  input  logic               InByteReady,
  output logic [7:0]         DataByte,
  output logic [NumDest-1:0] ClearAddr,
  output logic [NumDest-1:0] WriteByte,
  output logic [7:0]         MsgID,
  output logic               MsgComplete,
  output logic               MsgError,
  output logic               Busy
);

  localparam int unsigned DestW = (NumDest > 1) ? $clog2(NumDest) : 1;
  localparam int unsigned TmoW  = $clog2(TimeoutCycles + 1);

  state_e               state_q, state_d;
  logic [7:0]           count_q, count_d;
  logic [7:0]           rem_q, rem_d;
  logic [7:0]           msg_id_q, msg_id_d;
  logic [7:0]           data_q, data_d;
  logic [DestW-1:0]     dest_q, dest_d;
  logic [NumDest-1:0]   clear_addr_q, clear_addr_d;
  logic [NumDest-1:0]   write_q, write_d;
  logic                 complete_q, complete_d;
  logic                 error_q, error_d;

  logic                 tmo_expired;
  logic [7:0]           k;
  logic                 id_ok;
  logic                 count_bad;
  logic                 last_byte;

  // Destination index wraps in 8 bits, so IDs below FirstMsgID land out of range.
  assign k         = InByte - FirstMsgID;
  assign id_ok     = ({24'd0, k} < 32'(NumDest));
  assign count_bad = ({24'd0, InByte} > 32'(MaxPayload));
  assign last_byte = (rem_q == 8'd1);

  msg_timeout #(
    .Width(TmoW)
  ) u_timeout (
    .clk_i    (Clock),
    .rst_ni   (Clear_n),
    .clear_i  (InByteReady || (state_q == HUNT1)),
    .enable_i (state_q != HUNT1),
    .limit_i  (TmoW'(TimeoutCycles)),
    .expired_o(tmo_expired)
  );

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q      <= HUNT1;
      count_q      <= '0;
      rem_q        <= '0;
      msg_id_q     <= '0;
      data_q       <= '0;
      dest_q       <= '0;
      clear_addr_q <= '0;
      write_q      <= '0;
      complete_q   <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rem_q        <= rem_d;
      msg_id_q     <= msg_id_d;
      data_q       <= data_d;
      dest_q       <= dest_d;
      clear_addr_q <= clear_addr_d;
      write_q      <= write_d;
      complete_q   <= complete_d;
      error_q      <= error_d;
    end
  end

  // A byte arriving on the expiry cycle is dropped along with the frame.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    msg_id_d = msg_id_q;
    dest_d   = dest_q;
    if (tmo_expired) begin
      state_d = HUNT1;
    end else if (InByteReady) begin
      case (state_q)
        HUNT1: begin
          if (InByte == SyncByte1) state_d = HUNT2;
        end
        HUNT2: begin
          if (InByte == SyncByte2)      state_d = GET_COUNT;
          else if (InByte != SyncByte1) state_d = HUNT1;
        end
        GET_COUNT: begin
          count_d = InByte;
          rem_d   = InByte;
          state_d = count_bad ? HUNT1 : GET_ID;
        end
        GET_ID: begin
          msg_id_d = InByte;
          dest_d   = k[DestW-1:0];
          if (count_q == 8'd0) state_d = HUNT1;
          else if (id_ok)      state_d = PAYLOAD;
          else                 state_d = DISCARD;
        end
        PAYLOAD, DISCARD: begin
          rem_d = rem_q - 8'd1;
          if (last_byte) state_d = HUNT1;
        end
        default: state_d = HUNT1;
      endcase
    end
  end

  always_comb begin
    clear_addr_d = '0;
    write_d      = '0;
    complete_d   = 1'b0;
    error_d      = 1'b0;
    data_d       = data_q;
    if (tmo_expired) begin
      error_d = 1'b1;
    end else if (InByteReady) begin
      case (state_q)
        GET_COUNT: error_d = count_bad;
        GET_ID: begin
          if (id_ok) begin
            clear_addr_d = NumDest'(1) << k[DestW-1:0];
            complete_d   = (count_q == 8'd0);
          end else begin
            error_d = 1'b1;
          end
        end
        PAYLOAD: begin
          data_d     = InByte;
          write_d    = NumDest'(1) << dest_q;
          complete_d = last_byte;
        end
        default: ;
      endcase
    end
  end

  assign DataByte    = data_q;
  assign ClearAddr   = clear_addr_q;
  assign WriteByte   = write_q;
  assign MsgID       = msg_id_q;
  assign MsgComplete = complete_q;
  assign MsgError    = error_q;
  assign Busy        = (state_q != HUNT1);

endmodule

// File: tb/tb_msg_router.sv
// Directed bench for msg_router: a frame-level reference model predicts every
// output each cycle, and per-test literal pulse counts and payload bytes pin it.
module tb_msg_router;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] InByte;
  logic       InByteReady;
  logic [7:0] DataByte;
  logic [3:0] ClearAddr;
  logic [3:0] WriteByte;
  logic [7:0] MsgID;
  logic       MsgComplete;
  logic       MsgError;
  logic       Busy;

  msg_router #(
    .TimeoutCycles(TMO)
  ) dut (
    .Clock      (clk),
    .Clear_n    (rst_n),
    .InByte     (InByte),
    .InByteReady(InByteReady),
    .DataByte   (DataByte),
    .ClearAddr  (ClearAddr),
    .WriteByte  (WriteByte),
    .MsgID      (MsgID),
    .MsgComplete(MsgComplete),
    .MsgError   (MsgError),
    .Busy       (Busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_pos: 0 idle, 1 after sync1, 2 expecting count, 3 expecting id, 4+n payload byte n
  int         m_pos = 0, m_count = 0, m_dest = 0, m_idle = 0;
  logic [3:0] e_clear = '0, e_write = '0;
  logic [7:0] e_data = '0, e_id = '0;
  logic       e_cmp = 1'b0, e_err = 1'b0, e_busy = 1'b0;

  task automatic model_byte(input logic [7:0] b);
    int d;
    if (m_pos == 0) begin
      if (b == 8'h12) m_pos = 1;
    end else if (m_pos == 1) begin
      if (b == 8'h34)      m_pos = 2;
      else if (b != 8'h12) m_pos = 0;
    end else if (m_pos == 2) begin
      m_count = int'(b);
      if (m_count > 32) begin e_err = 1'b1; m_pos = 0; end
      else m_pos = 3;
    end else if (m_pos == 3) begin
      e_id = b;
      d = (int'(b) - 16 + 256) % 256;
      if (d < 4) begin
        e_clear = 4'(1 << d);
        m_dest  = d;
        e_cmp   = (m_count == 0);
      end else begin
        e_err  = 1'b1;
        m_dest = -1;
      end
      m_pos = (m_count == 0) ? 0 : 4;
    end else begin
      if (m_dest >= 0) begin
        e_write = 4'(1 << m_dest);
        e_data  = b;
      end
      if (m_pos - 4 == m_count - 1) begin
        e_cmp = (m_dest >= 0);
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pos = 0; m_count = 0; m_dest = 0; m_idle = 0;
        e_clear = '0; e_write = '0; e_data = '0; e_id = '0;
        e_cmp = 1'b0; e_err = 1'b0; e_busy = 1'b0;
      end else begin
        logic take;
        take    = InByteReady;
        e_clear = '0; e_write = '0; e_cmp = 1'b0; e_err = 1'b0;
        if (m_pos == 0) m_idle = 0;
        else if (m_idle == TMO) begin
          e_err = 1'b1; m_pos = 0; m_idle = 0; take = 1'b0;
        end else if (InByteReady) m_idle = 0;
        else m_idle++;
        if (take) model_byte(InByte);
        e_busy = (m_pos != 0);
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [7:0] exp_q[$];
  int         clr_cnt = 0, wr_cnt = 0, cmp_cnt = 0, err_cnt = 0;
  logic [3:0] last_clr = '0;

  initial begin
    forever begin
      @(negedge clk);
      check("DataByte",    32'(DataByte),    32'(e_data));
      check("ClearAddr",   32'(ClearAddr),   32'(e_clear));
      check("WriteByte",   32'(WriteByte),   32'(e_write));
      check("MsgID",       32'(MsgID),       32'(e_id));
      check("MsgComplete", 32'(MsgComplete), 32'(e_cmp));
      check("MsgError",    32'(MsgError),    32'(e_err));
      check("Busy",        32'(Busy),        32'(e_busy));
      if (ClearAddr != '0) begin clr_cnt++; last_clr = ClearAddr; end
      if (MsgComplete) cmp_cnt++;
      if (MsgError)    err_cnt++;
      if (WriteByte != '0) begin
        wr_cnt++;
        if (exp_q.size() == 0) check("wr_unexpected", 32'(DataByte), 32'hFFFF_FFFF);
        else                   check("wr_data", 32'(DataByte), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] tx_q[$];
  int s_clr, s_wr, s_cmp, s_err;

  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk);
    InByte      = b;
    InByteReady = 1'b1;
    if (gap > 0) begin
      @(negedge clk);
      InByteReady = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic run(input int gap);
    while (tx_q.size() > 0) send(tx_q.pop_front(), gap);
    @(negedge clk);
    InByteReady = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic snap();
    s_clr = clr_cnt; s_wr = wr_cnt; s_cmp = cmp_cnt; s_err = err_cnt;
  endtask

  task automatic expect_counts(input string t, input int clr, input logic [3:0] lclr,
                               input int wr, input int cmp, input int err);
    check({t, "_n_clear"}, 32'(clr_cnt - s_clr), 32'(clr));
    if (clr > 0) check({t, "_clear_addr"}, 32'(last_clr), 32'(lclr));
    check({t, "_n_write"}, 32'(wr_cnt - s_wr),   32'(wr));
    check({t, "_n_cmp"},   32'(cmp_cnt - s_cmp), 32'(cmp));
    check({t, "_n_err"},   32'(err_cnt - s_err), 32'(err));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit got;
    rst_n       = 1'b0;
    InByte      = '0;
    InByteReady = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", {DataByte, ClearAddr, WriteByte, MsgID, MsgComplete, MsgError, Busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Back-to-back frame to destination 1
    snap();
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    tx_q  = '{8'h12, 8'h34, 8'h04, 8'h11, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run(0);
    expect_counts("t1", 1, 4'b0010, 4, 1, 0);
    check("t1_data_hold", 32'(DataByte), 32'hDD);

    // Noise before the header, zero-length frame to destination 0
    snap();
    tx_q = '{8'h55, 8'h12, 8'h12, 8'h34, 8'h00, 8'h10};
    run(1);
    expect_counts("t2", 1, 4'b0001, 0, 1, 0);

    // Unknown ID discarded, then a frame to destination 3
    snap();
    exp_q = '{8'h77};
    tx_q  = '{8'h12, 8'h34, 8'h02, 8'h20, 8'h01, 8'h02, 8'h12, 8'h34, 8'h01, 8'h13, 8'h77};
    run(1);
    expect_counts("t3", 1, 4'b1000, 1, 1, 1);

    // Oversize count aborts right after the count byte
    snap();
    tx_q = '{8'h12, 8'h34, 8'h21, 8'h10};
    run(1);
    expect_counts("t4", 0, 4'b0000, 0, 0, 1);
    check("t4_msgid_kept", 32'(MsgID), 32'h13);
    check("t4_busy", 32'(Busy), 32'd0);

    // Timeout inside a payload, then a clean frame to destination 2
    snap();
    exp_q = '{8'hAA};
    tx_q  = '{8'h12, 8'h34, 8'h03, 8'h10, 8'hAA};
    while (tx_q.size() > 0) send(tx_q.pop_front(), 1);
    got = 1'b0;
    for (int i = 0; i < 2 * TMO && !got; i++) begin
      @(negedge clk);
      if (MsgError) got = 1'b1;
    end
    check("t5_timeout_seen", 32'(got), 32'd1);
    @(negedge clk);
    check("t5_busy_after", 32'(Busy), 32'd0);
    expect_counts("t5a", 1, 4'b0001, 1, 0, 1);
    snap();
    exp_q = '{8'h5A};
    tx_q  = '{8'h12, 8'h34, 8'h01, 8'h12, 8'h5A};
    run(1);
    expect_counts("t5b", 1, 4'b0100, 1, 1, 0);

    // Asynchronous reset while a payload write strobe is high
    snap();
    tx_q = '{8'h12, 8'h34, 8'h02, 8'h11};
    while (tx_q.size() > 0) send(tx_q.pop_front(), 1);
    @(negedge clk);
    InByte      = 8'h01;
    InByteReady = 1'b1;
    @(posedge clk);
    #1;
    check("t6_write_before_rst", 32'(WriteByte), 32'(4'b0010));
    #1;
    rst_n       = 1'b0;
    InByteReady = 1'b0;
    #1;
    check("t6_rst_outs", {DataByte, ClearAddr, WriteByte, MsgID, MsgComplete, MsgError, Busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    expect_counts("t6a", 1, 4'b0010, 0, 0, 0);
    snap();
    exp_q = '{8'h99};
    tx_q  = '{8'h12, 8'h34, 8'h01, 8'h11, 8'h99};
    run(1);
    expect_counts("t6b", 1, 4'b0010, 1, 1, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
